// File: rtl/alu_defs.sv
// Shared ALU op codes and multiply-sequencer state encodings.
package alu_defs;

  typedef enum logic [2:0] {
    ALU_ROL = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SRL = 3'b011,
    ALU_ADD = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/iter_cnt.sv
// Iteration counter for the multiply loop: sync clear, enable, terminal count at all-ones.
module iter_cnt
  import alu_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/alu_mult_seq.sv
// Unsigned NxN shift-and-add multiplier that borrows the shared ALU adder while iterating.
//
// state | meaning
// IDLE  | ready for operands; ALU inputs parked at zero
// ITER  | one add-and-shift per cycle, 16 cycles
// DONE  | product presented until the consumer takes it
module alu_mult_seq
  import alu_defs::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] mplier,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] prod_hi,
  output logic [N-1:0] prod_lo,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [2:0]   alu_Op,
  output logic         alu_Cin,
  output logic         alu_invA,
  output logic         alu_invB,
  output logic         alu_sign,
  input  logic [N-1:0] alu_Out,
  input  logic         alu_Ofl
);

  seq_state_e   state;
  logic [N-1:0] mc;
  logic [N-1:0] acc_hi;
  logic [N-1:0] acc_lo;
  logic         iter_tc;

  iter_cnt u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) && req_valid),
    .en    (state == ITER),
    .tc    (iter_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mc     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mc     <= mcand;
            acc_hi <= '0;
            acc_lo <= mplier;
            state  <= ITER;
          end
        end
        ITER: begin
          // carry out of the add becomes the new top bit of the 2N+1 bit shift
          {acc_hi, acc_lo} <= {alu_Ofl, alu_Out, acc_lo[N-1:1]};
          if (iter_tc) state <= DONE;
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign prod_hi    = acc_hi;
  assign prod_lo    = acc_lo;

  assign alu_A    = (state == ITER) ? acc_hi : '0;
  assign alu_B    = ((state == ITER) && acc_lo[0]) ? mc : '0;
  assign alu_Op   = ALU_ADD;
  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq with a behavioural unsigned adder standing in for the ALU.
module tb_alu_mult_seq;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] prod_hi;
  logic [N-1:0] prod_lo;
  logic [N-1:0] alu_A;
  logic [N-1:0] alu_B;
  logic [2:0]   alu_Op;
  logic         alu_Cin;
  logic         alu_invA;
  logic         alu_invB;
  logic         alu_sign;
  logic [N-1:0] alu_Out;
  logic         alu_Ofl;
  logic [N:0]   alu_sum;

  alu_mult_seq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mcand      (mcand),
    .mplier     (mplier),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .prod_hi    (prod_hi),
    .prod_lo    (prod_lo),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Op     (alu_Op),
    .alu_Cin    (alu_Cin),
    .alu_invA   (alu_invA),
    .alu_invB   (alu_invB),
    .alu_sign   (alu_sign),
    .alu_Out    (alu_Out),
    .alu_Ofl    (alu_Ofl)
  );

  // unsigned add: overflow is the carry out
  assign alu_sum = {1'b0, alu_A} + {1'b0, alu_B} + {{N{1'b0}}, alu_Cin};
  assign alu_Out = alu_sum[N-1:0];
  assign alu_Ofl = alu_sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
    int             hold;
  } vec_t;

  vec_t           vecs[7];
  logic [2*N-1:0] sb[$];
  int             n_pass;
  int             n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_idle_alu(input string tag);
    check({tag, "_alu_A"}, 32'(alu_A), 32'h0);
    check({tag, "_alu_B"}, 32'(alu_B), 32'h0);
    check({tag, "_alu_ctl"}, {24'h0, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign, 1'b0},
          {24'h0, 3'b100, 5'b0});
  endtask

  // Presents a pair at a negedge, lets edge T accept it, returns at the negedge after T.
  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp,
                        input bit keep_valid, input logic [N-1:0] na, input logic [N-1:0] nb);
    @(negedge clk);
    mcand     = a;
    mplier    = b;
    req_valid = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'h1);
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (keep_valid) begin
      mcand  = na;
      mplier = nb;
    end else begin
      req_valid = 1'b0;
      mcand     = N'($urandom);
      mplier    = N'($urandom);
    end
    check("first_iter_alu_A", 32'(alu_A), 32'h0);
    check("first_iter_alu_B", 32'(alu_B), b[0] ? 32'(a) : 32'h0);
  endtask

  // Starts at the negedge after the accept edge; finishes at the negedge after the handshake edge.
  task automatic wait_resp(input int hold);
    int             lat;
    bit             busy_ok;
    logic [2*N-1:0] held;
    logic [2*N-1:0] exp;
    lat     = 0;
    busy_ok = 1'b1;
    while (!resp_valid && lat < 40) begin
      if (req_ready !== 1'b0 || alu_Op !== 3'b100 || alu_Cin !== 1'b0 ||
          alu_invA !== 1'b0 || alu_invB !== 1'b0 || alu_sign !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("busy_outputs", 32'(busy_ok), 32'h1);
    check("latency", 32'(lat), 32'd16);
    if (!resp_valid) return;
    held    = {prod_hi, prod_lo};
    busy_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {prod_hi, prod_lo} !== held) busy_ok = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) begin
      check("backpressure_stable", 32'(busy_ok), 32'h1);
      check("backpressure_prod", {prod_hi, prod_lo}, held);
    end
    resp_ready = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'h0, 32'h1);
    end else begin
      exp = sb.pop_front();
      check("product", {prod_hi, prod_lo}, exp);
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_hs_resp_valid", 32'(resp_valid), 32'h0);
    check("post_hs_req_ready", 32'(req_ready), 32'h1);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    mcand      = '0;
    mplier     = '0;

    vecs[0] = '{a: 16'h0003, b: 16'h0005, prod: 32'h0000_000F, hold: 0};
    vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, prod: 32'hFFFE_0001, hold: 0};
    vecs[2] = '{a: 16'h1234, b: 16'h0000, prod: 32'h0000_0000, hold: 0};
    vecs[3] = '{a: 16'h0000, b: 16'hABCD, prod: 32'h0000_0000, hold: 0};
    vecs[4] = '{a: 16'h8000, b: 16'h0002, prod: 32'h0001_0000, hold: 5};
    vecs[5] = '{a: 16'h1234, b: 16'h5678, prod: 32'h0626_0060, hold: 2};
    vecs[6] = '{a: 16'h00FF, b: 16'h0101, prod: 32'h0000_FFFF, hold: 0};

    #12;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_prod", {prod_hi, prod_lo}, 32'h0);
    check_idle_alu("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0, '0, '0);
      wait_resp(vecs[i].hold);
    end
    check_idle_alu("idle");

    // second request held on the bus for the whole first transaction
    accept(16'h0007, 16'h0009, 32'd63, 1'b1, 16'h0101, 16'h0011);
    wait_resp(0);
    sb.push_back(32'h0000_1111);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("queued_accepted", 32'(req_ready), 32'h0);
    wait_resp(1);

    // reset in the middle of the loop discards the product
    accept(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, '0, '0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h1);
    check("midrst_prod", {prod_hi, prod_lo}, 32'h0);
    check_idle_alu("midrst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    accept(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, '0, '0);
    wait_resp(0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
